mem_master: RTL

- Load/store initiator that drives the byte-addressable data memory port (op, rw, addr, data_w, data_r) on behalf of the core.
- Accepts one valid/ready request at a time: byte, halfword or word; load or store.
- Loads are sign- or zero-extended.
- Sub-word stores use read-modify-write, because the memory always writes 4 bytes at addr..addr+3.
- Sits between the execute stage and the memory.

---
 rtl/mem_master.sv | 117 +++++++++++
 1 files changed

// File: rtl/mem_master.sv
// Load/store initiator: one request at a time, sign/zero-extended loads, RMW for sub-word stores.
// Optional alignment check enabled by defining MEM_MASTER_ALIGN_CHECK_EN.
module mem_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_op,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_w,
  input  logic [DATA_WIDTH-1:0] mem_data_r
);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t                state, state_nx;
  logic                  we_q, uns_q, bad;
  logic [1:0]            size_q;
  logic [DATA_WIDTH-1:0] wdata_q, ld_ext, st_merge;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RSP);

`ifdef MEM_MASTER_ALIGN_CHECK_EN
  assign bad = (req_size == 2'd3) ||
               (req_size == 2'd1 && req_addr[0]) ||
               (req_size == 2'd2 && req_addr[1:0] != 2'd0);
`else
  assign bad = (req_size == 2'd3);
`endif

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid) begin
        if (bad)                            state_nx = RSP;
        else if (!req_we || req_size != 2'd2) state_nx = RD;
        else                                state_nx = WR;
      end
      RD:      state_nx = we_q ? WR : RSP;
      WR:      state_nx = RSP;
      RSP:     if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Load extension and sub-word merge both work on the word read during RD.
  always_comb begin
    ld_ext   = mem_data_r;
    st_merge = wdata_q;
    case (size_q)
      2'd0: begin
        ld_ext   = {{(DATA_WIDTH-8){~uns_q & mem_data_r[7]}}, mem_data_r[7:0]};
        st_merge = {mem_data_r[DATA_WIDTH-1:8], wdata_q[7:0]};
      end
      2'd1: begin
        ld_ext   = {{(DATA_WIDTH-16){~uns_q & mem_data_r[15]}}, mem_data_r[15:0]};
        st_merge = {mem_data_r[DATA_WIDTH-1:16], wdata_q[15:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      mem_op     <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_data_w <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'd0;
      wdata_q    <= '0;
    end else begin
      mem_op <= (state_nx == RD) || (state_nx == WR);
      mem_rw <= (state_nx == WR);
      case (state)
        IDLE: if (req_valid) begin
          we_q       <= req_we;
          uns_q      <= req_unsigned;
          size_q     <= req_size;
          wdata_q    <= req_wdata;
          mem_addr   <= req_addr;
          mem_data_w <= req_wdata;
          resp_rdata <= '0;
          resp_err   <= bad;
        end
        RD: begin
          if (we_q) mem_data_w <= st_merge;
          else      resp_rdata <= ld_ext;
        end
        default: ;
      endcase
    end
  end

endmodule
